codec_sched: RTL and testbench



---
 rtl/codec_sched.sv | 91 +++++++++
 tb/tb_codec_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/codec_sched.sv
// codec_sched: sequences one compression job at a time, drives the codec control word and counts packer puts.
// Optional RUN-state inactivity watchdog enabled by defining CODEC_SCHED_TIMEOUT_EN.
module codec_sched #(
  parameter int WCNT_W = 16,
  parameter int TMO_W  = 12
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [23:0]       job_dc,
  output logic              job_done,
  output logic [1:0]        job_status,
  output logic [WCNT_W-1:0] job_words,
  output logic              busy,
  output logic [23:0]       dc,
  output logic              en_start,
  output logic              de_start,
  output logic              m_enable,
  output logic              codec_clr,
  input  logic              m_dst_putn,
  input  logic              m_endn
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [1:0] st, st_nxt;
  logic [WCNT_W-1:0] cnt;
  logic put, tmo_hit;
  assign job_ready = state == IDLE;
  // the put/end strobes float while the bus is not granted, so gate them by state
  assign put = !m_dst_putn && (state == RUN || state == DRAIN);
`ifdef CODEC_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo;
  assign tmo_hit = &tmo;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) tmo <= '0;
    else if (state == LOAD || put) tmo <= '0;
    else if (state == RUN) tmo <= tmo + 1'b1;
`else
  assign tmo_hit = TMO_W < 1;
`endif
  always_comb begin
    nxt = state;
    st_nxt = st;
    case (state)
      IDLE: nxt = job_valid ? LOAD : IDLE;
      LOAD: begin
        nxt = (dc[6] ^ dc[5]) ? RUN : DONE;
        st_nxt = (dc[6] ^ dc[5]) ? 2'b00 : {1'b1, dc[5]};
      end
      RUN: begin
        nxt = !m_endn ? DRAIN : tmo_hit ? DONE : RUN;
        st_nxt = !m_endn ? 2'b00 : tmo_hit ? 2'b01 : st;
      end
      DRAIN: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      st <= 2'b00;
      cnt <= '0;
      dc <= '0;
      en_start <= 1'b0;
      de_start <= 1'b0;
      m_enable <= 1'b0;
      codec_clr <= 1'b0;
      job_done <= 1'b0;
      job_status <= 2'b00;
      job_words <= '0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      st <= st_nxt;
      busy <= nxt != IDLE;
      m_enable <= nxt == RUN || nxt == DRAIN;
      en_start <= state == LOAD && dc[6:5] == 2'b01;
      de_start <= state == LOAD && dc[6:5] == 2'b10;
      job_done <= state == DONE;
      codec_clr <= state == DONE;
      if (state == IDLE && job_valid) begin
        dc <= job_dc;
        cnt <= '0;
      end else if (put && !(&cnt)) cnt <= cnt + 1'b1;
      if (state == DONE) begin
        job_words <= cnt;
        job_status <= st;
      end
    end
endmodule

// File: tb/tb_codec_sched.sv
// tb_codec_sched: directed job table plus hand sequences for back-to-back, reset abort and watchdog.
module tb_codec_sched;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic job_valid = 1'b0, m_dst_putn = 1'b1, m_endn = 1'b1;
  logic [23:0] job_dc = '0;
  logic job_ready, job_done, busy, en_start, de_start, m_enable, codec_clr;
  logic [1:0] job_status;
  logic [15:0] job_words;
  logic [23:0] dc;
  logic job_ready4, job_done4, busy4, en_start4, de_start4, m_enable4, codec_clr4;
  logic [1:0] job_status4;
  logic [3:0] job_words4;
  logic [23:0] dc4;
  int n_cmp = 0, n_bad = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  codec_sched #(.WCNT_W(16), .TMO_W(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .job_valid(job_valid), .job_ready(job_ready),
    .job_dc(job_dc), .job_done(job_done), .job_status(job_status), .job_words(job_words),
    .busy(busy), .dc(dc), .en_start(en_start), .de_start(de_start), .m_enable(m_enable),
    .codec_clr(codec_clr), .m_dst_putn(m_dst_putn), .m_endn(m_endn));

  codec_sched #(.WCNT_W(4), .TMO_W(4)) dut4 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .job_valid(job_valid), .job_ready(job_ready4),
    .job_dc(job_dc), .job_done(job_done4), .job_status(job_status4), .job_words(job_words4),
    .busy(busy4), .dc(dc4), .en_start(en_start4), .de_start(de_start4), .m_enable(m_enable4),
    .codec_clr(codec_clr4), .m_dst_putn(m_dst_putn), .m_endn(m_endn));

  typedef struct {
    logic [23:0] dc;
    int puts;
    bit coinc;
    bit dput;
    int en_n;
    int de_n;
    bit me;
    logic [1:0] st;
    int words;
    int words4;
    int dcyc;
  } vec_t;
  vec_t v[5];

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // runs one job from IDLE; the packer model only puts while the bus is granted
  task automatic run_job(input vec_t r, input string nm);
    int cyc = 0, left = r.puts, p = 0, en_n = 0, de_n = 0;
    bit me = 0, done = 0;
    job_dc = r.dc;
    job_valid = 1'b1;
    chk({nm, "_ready"}, job_ready, 1);
    tick;
    cyc = 1;
    job_valid = 1'b0;
    job_dc = ~r.dc;
    chk({nm, "_busy"}, busy, 1);
    while (!done && cyc < 200) begin
      if (en_start) en_n++;
      if (de_start) de_n++;
      if (m_enable) me = 1;
      if (job_done) done = 1;
      else begin
        m_dst_putn = 1'b1;
        m_endn = 1'b1;
        if (m_enable && p == 0) begin
          if (left > 0) begin
            m_dst_putn = 1'b0;
            left--;
          end else begin
            m_endn = 1'b0;
            m_dst_putn = !r.coinc;
            p = 1;
          end
        end else if (m_enable && p == 1) begin
          m_dst_putn = !r.dput;
          p = 2;
        end
        tick;
        cyc++;
      end
    end
    m_dst_putn = 1'b1;
    m_endn = 1'b1;
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_done_cyc"}, cyc, r.dcyc);
    chk({nm, "_en_start"}, en_n, r.en_n);
    chk({nm, "_de_start"}, de_n, r.de_n);
    chk({nm, "_m_enable"}, me, r.me);
    chk({nm, "_status"}, job_status, r.st);
    chk({nm, "_words"}, job_words, r.words);
    chk({nm, "_words4"}, job_words4, r.words4);
    chk({nm, "_done4"}, job_done4, 1);
    chk({nm, "_clr"}, codec_clr, 1);
    chk({nm, "_idle_busy"}, busy, 0);
    tick;
    chk({nm, "_done_pulse"}, job_done, 0);
    chk({nm, "_words_hold"}, job_words, r.words);
  endtask

  initial begin
    bit seen;
    v[0] = '{24'h000020, 8, 0, 0, 1, 0, 1, 2'b00, 8, 8, 13};
    v[1] = '{24'h000040, 3, 1, 1, 0, 1, 1, 2'b00, 5, 5, 8};
    v[2] = '{24'h000020, 20, 0, 0, 1, 0, 1, 2'b00, 20, 15, 25};
    v[3] = '{24'hFFFF9F, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 3};
    v[4] = '{24'h000060, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 3};
    #3;
    chk("rst_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dc", dc, 0);
    chk("rst_m_enable", m_enable, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_status", job_status, 0);
    chk("rst_words", job_words, 0);
    chk("rst_starts", {en_start, de_start, codec_clr}, 0);
    tick;
    wb_rst_i = 1'b0;
    chk("rel_ready", job_ready, 1);
    tick;
    for (int i = 0; i < 5; i++) run_job(v[i], $sformatf("job%0d", i));

    seen = 0;
    job_valid = 1'b1;
    job_dc = 24'h000000;
    for (int c = 0; c <= 6; c++) begin
      if (m_enable) seen = 1;
      if (c == 1) chk("b2b_load_ready", job_ready, 0);
      if (c == 3) begin
        chk("b2b_done1", job_done, 1);
        chk("b2b_status1", job_status, 2'b10);
        chk("b2b_ready1", job_ready, 1);
        job_dc = 24'h000060;
      end
      if (c == 4) chk("b2b_accept2", job_ready, 0);
      if (c == 6) begin
        chk("b2b_done2", job_done, 1);
        chk("b2b_status2", job_status, 2'b11);
        job_valid = 1'b0;
      end
      tick;
    end
    chk("b2b_m_enable", seen, 0);

    run_job(v[2], "presat");
    job_dc = 24'h000020;
    job_valid = 1'b1;
    tick;
    job_valid = 1'b0;
    tick;
    chk("abort_m_enable_on", m_enable, 1);
    m_dst_putn = 1'b0;
    repeat (3) tick;
    m_dst_putn = 1'b1;
    wb_rst_i = 1'b1;
    #1;
    chk("abort_m_enable", m_enable, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", job_ready, 1);
    chk("abort_words", job_words, 0);
    chk("abort_dc", dc, 0);
    tick;
    wb_rst_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (job_done) seen = 1;
      tick;
    end
    chk("abort_no_done", seen, 0);
    run_job(v[0], "after_abort");

    job_dc = 24'h000020;
    job_valid = 1'b1;
    tick;
    job_valid = 1'b0;
    tick;
    m_dst_putn = 1'b0;
    repeat (2) tick;
    m_dst_putn = 1'b1;
    seen = 0;
`ifdef CODEC_SCHED_TIMEOUT_EN
    for (int c = 0; c < 40 && !seen; c++) begin
      if (job_done) seen = 1;
      else tick;
    end
    chk("tmo_done", seen, 1);
    chk("tmo_status", job_status, 2'b01);
    chk("tmo_words", job_words, 2);
`else
    for (int c = 0; c < 100; c++) begin
      if (job_done) seen = 1;
      tick;
    end
    chk("notmo_no_done", seen, 0);
    chk("notmo_busy", busy, 1);
    chk("notmo_m_enable", m_enable, 1);
    m_endn = 1'b0;
    tick;
    m_endn = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (job_done) seen = 1;
      else tick;
    end
    chk("notmo_end_done", seen, 1);
    chk("notmo_status", job_status, 2'b00);
    chk("notmo_words", job_words, 2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
